pwm_breath_sequencer: RTL and testbench

Sequences the LED brightness duty value through a programmable breathing pattern: ramp up, hold at peak, ramp down, hold at floor, and repeat.
- Configuration (floor, peak, hold time, repeat count) is latched on a start handshake.
- The block produces both the 8-bit duty value and the PWM waveform for one LED channel.
- It sits between the board-level control (buttons/AXI-lite registers) and the LED pin.

---
 rtl/pwm_seq_pkg.sv | 19 +
 rtl/pwm_gen.sv | 29 ++
 rtl/pwm_breath_sequencer.sv | 139 +++++++++++++
 tb/tb_pwm_breath_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared state encoding, widths and small helpers for the LED breathing sequencer.
package pwm_seq_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int CNT8_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HIGH = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LOW  = 3'd4
  } state_e;

  function automatic logic [CNT8_W-1:0] sat_inc8(input logic [CNT8_W-1:0] v);
    return (v == {CNT8_W{1'b1}}) ? v : v + CNT8_W'(1);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a registered compare against the duty value.
module pwm_gen
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              pwm_out_o
);

  logic [DUTY_W-1:0] cnt_q;
  logic              pwm_q;

  // Counter runs regardless of sequencer state; output lags duty by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + DUTY_W'(1);
      pwm_q <= (cnt_q < duty_i);
    end
  end

  assign pwm_out_o = pwm_q;

endmodule

// File: rtl/pwm_breath_sequencer.sv
// Breathing-pattern duty sequencer: ramp up, hold at peak, ramp down, hold at floor,
// repeated for a latched number of breaths, driving one PWM LED channel.
module pwm_breath_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int STEP_DIV = 1000000,
  parameter int CNT_W    = 20,
  parameter int DUTY_W   = DUTY_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DUTY_W-1:0] cfg_floor_i,
  input  logic [DUTY_W-1:0] cfg_peak_i,
  input  logic [CNT8_W-1:0] cfg_hold_i,
  input  logic [CNT8_W-1:0] cfg_cycles_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              pwm_out_o,
  output logic [2:0]        phase_o
);

  state_e            state_q;
  logic [CNT_W-1:0]  pre_q;
  logic [DUTY_W-1:0] duty_q, floor_q, peak_q;
  logic [CNT8_W-1:0] hold_q, cycles_q, hold_cnt_q, cycle_cnt_q;
  logic              done_q, cfg_err_q;

  logic              tick_s, hold_end_s, last_breath_s;
  logic [DUTY_W-1:0] duty_up_d, duty_dn_d;
  logic [CNT8_W-1:0] cycle_cnt_d;

  assign tick_s        = (pre_q == CNT_W'(STEP_DIV - 1));
  assign duty_up_d     = duty_q + DUTY_W'(1);
  assign duty_dn_d     = duty_q - DUTY_W'(1);
  assign hold_end_s    = (hold_cnt_q == hold_q);
  // Widened compare so a 255-breath run cannot alias through the counter wrap.
  assign last_breath_s = (cycles_q != CNT8_W'(0)) &&
                         (({1'b0, cycle_cnt_q} + (CNT8_W+1)'(1)) == {1'b0, cycles_q});
  assign cycle_cnt_d   = sat_inc8(cycle_cnt_q);

  // Sequencer FSM with prescaler, hold/breath counters and registered status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      duty_q      <= '0;
      floor_q     <= '0;
      peak_q      <= '0;
      hold_q      <= '0;
      cycles_q    <= '0;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        pre_q <= '0;
        if (start_i && !stop_i) begin
          if (cfg_floor_i >= cfg_peak_i) begin
            cfg_err_q <= 1'b1;
          end else begin
            floor_q     <= cfg_floor_i;
            peak_q      <= cfg_peak_i;
            hold_q      <= cfg_hold_i;
            cycles_q    <= cfg_cycles_i;
            duty_q      <= cfg_floor_i;
            cycle_cnt_q <= '0;
            hold_cnt_q  <= '0;
            state_q     <= ST_RAMP_UP;
          end
        end
      end else if (stop_i) begin
        state_q <= ST_IDLE;
        duty_q  <= '0;
        pre_q   <= '0;
      end else begin
        pre_q <= tick_s ? '0 : pre_q + CNT_W'(1);
        if (tick_s) begin
          case (state_q)
            ST_RAMP_UP: begin
              duty_q <= duty_up_d;
              if (duty_up_d == peak_q) begin
                state_q    <= ST_HOLD_HIGH;
                hold_cnt_q <= '0;
              end
            end
            ST_HOLD_HIGH: begin
              if (hold_end_s) state_q <= ST_RAMP_DOWN;
              else            hold_cnt_q <= hold_cnt_q + CNT8_W'(1);
            end
            ST_RAMP_DOWN: begin
              duty_q <= duty_dn_d;
              if (duty_dn_d == floor_q) begin
                state_q    <= ST_HOLD_LOW;
                hold_cnt_q <= '0;
              end
            end
            ST_HOLD_LOW: begin
              if (!hold_end_s) begin
                hold_cnt_q <= hold_cnt_q + CNT8_W'(1);
              end else if (last_breath_s) begin
                state_q <= ST_IDLE;
                duty_q  <= '0;
                done_q  <= 1'b1;
              end else begin
                cycle_cnt_q <= cycle_cnt_d;
                state_q     <= ST_RAMP_UP;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              duty_q  <= '0;
            end
          endcase
        end
      end
    end
  end

  pwm_gen #(.DUTY_W(DUTY_W)) u_pwm_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .duty_i    (duty_q),
    .pwm_out_o (pwm_out_o)
  );

  assign busy_o    = (state_q != ST_IDLE);
  assign phase_o   = state_q;
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;
  assign duty_o    = duty_q;

endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Self-checking bench: table-driven vectors, hand sequences and randomized breaths
// checked against a tick-level timeline model built from the breathing rules.
module tb_pwm_breath_sequencer;

  localparam int STEP_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] cfg_floor, cfg_peak, cfg_hold, cfg_cycles;
  logic       busy, done, cfg_err, pwm_out;
  logic [7:0] duty;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  pwm_breath_sequencer #(.STEP_DIV(STEP_DIV), .CNT_W(20), .DUTY_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stop_i       (stop),
    .cfg_floor_i  (cfg_floor),
    .cfg_peak_i   (cfg_peak),
    .cfg_hold_i   (cfg_hold),
    .cfg_cycles_i (cfg_cycles),
    .busy_o       (busy),
    .done_o       (done),
    .cfg_err_o    (cfg_err),
    .duty_o       (duty),
    .pwm_out_o    (pwm_out),
    .phase_o      (phase)
  );

  always #5 clk = ~clk;

  // Reference PWM counter: cleared by reset, otherwise free-running.
  logic [7:0] m_cnt;
  always @(posedge clk) begin
    if (rst) m_cnt <= 8'd0;
    else     m_cnt <= m_cnt + 8'd1;
  end

  typedef struct {
    logic       start, stop;
    logic [7:0] fl, pk, hd, cy;
    int         len;
    logic [7:0] duty;
    logic       busy, done, err;
    logic [2:0] ph;
  } vec_t;

  vec_t tbl [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one start and checks every cycle of the breath against a timeline
  // built from the rules: initial floor 1 tick, peak hold+2 ticks, floor between
  // breaths hold+2 ticks, final floor hold+1 ticks, one tick per ramp value.
  task automatic run_breath(input int fl, input int pk, input int hd, input int cy,
                            input bit noise);
    int         ticks[$];
    int         q[$];
    int         prev;
    logic [7:0] cb;
    ticks = {};
    q = {};
    ticks.push_back(fl);
    for (int b = 0; b < cy; b++) begin
      for (int v = fl + 1; v < pk; v++) ticks.push_back(v);
      for (int k = 0; k < hd + 2; k++) ticks.push_back(pk);
      for (int v = pk - 1; v > fl; v--) ticks.push_back(v);
      for (int k = 0; k < ((b == cy - 1) ? hd + 1 : hd + 2); k++) ticks.push_back(fl);
    end
    foreach (ticks[t]) for (int k = 0; k < STEP_DIV; k++) q.push_back(ticks[t]);

    start = 1'b1; stop = 1'b0;
    cfg_floor = 8'(fl); cfg_peak = 8'(pk); cfg_hold = 8'(hd); cfg_cycles = 8'(cy);
    prev = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0 && noise) begin
        start      = 1'($urandom_range(0, 1));
        cfg_floor  = 8'($urandom);
        cfg_peak   = 8'($urandom);
        cfg_hold   = 8'($urandom);
        cfg_cycles = 8'($urandom);
      end
      step();
      if (i == 0) start = 1'b0;
      cb = m_cnt - 8'd1;
      chk("run duty", int'(duty), q[i]);
      chk("run busy", int'(busy), 1);
      chk("run done", int'(done), 0);
      chk("run pwm", int'(pwm_out), (int'(cb) < prev) ? 1 : 0);
      prev = q[i];
    end
    start = 1'b0;
    step();
    cb = m_cnt - 8'd1;
    chk("end duty", int'(duty), 0);
    chk("end busy", int'(busy), 0);
    chk("end done", int'(done), 1);
    chk("end phase", int'(phase), 0);
    chk("end pwm", int'(pwm_out), (int'(cb) < prev) ? 1 : 0);
    step();
    chk("post done", int'(done), 0);
    chk("post pwm", int'(pwm_out), 0);
  endtask

  task automatic wait_duty(input int val, input int budget, input string name);
    int n = 0;
    while (int'(duty) != val && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(duty), val);
  endtask

  initial begin
    int hi;
    tbl[0]  = '{1'b1, 1'b0, 8'd10,  8'd13,  8'd1, 8'd1, 1,  8'd10, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[1]  = '{1'b0, 1'b0, 8'd10,  8'd13,  8'd1, 8'd1, 3,  8'd10, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[2]  = '{1'b1, 1'b0, 8'd0,   8'd255, 8'd9, 8'd0, 4,  8'd11, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[3]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 4,  8'd12, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 8,  8'd13, 1'b1, 1'b0, 1'b0, 3'd2};
    tbl[5]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 4,  8'd13, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[6]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 4,  8'd12, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[7]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 4,  8'd11, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[8]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 8,  8'd10, 1'b1, 1'b0, 1'b0, 3'd4};
    tbl[9]  = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 1,  8'd0,  1'b0, 1'b1, 1'b0, 3'd0};
    tbl[10] = '{1'b0, 1'b0, 8'd50,  8'd60,  8'd0, 8'd5, 2,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 8'd20,  8'd20,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b1, 3'd0};
    tbl[12] = '{1'b0, 1'b0, 8'd20,  8'd20,  8'd1, 8'd1, 2,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b1, 1'b0, 8'd30,  8'd20,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b1, 3'd0};
    tbl[14] = '{1'b0, 1'b0, 8'd30,  8'd20,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[15] = '{1'b1, 1'b1, 8'd10,  8'd13,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[16] = '{1'b1, 1'b1, 8'd20,  8'd20,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[17] = '{1'b0, 1'b0, 8'd10,  8'd13,  8'd1, 8'd1, 3,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[18] = '{1'b0, 1'b1, 8'd10,  8'd13,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[19] = '{1'b0, 1'b0, 8'd10,  8'd13,  8'd1, 8'd1, 1,  8'd0,  1'b0, 1'b0, 1'b0, 3'd0};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_floor = 8'd0; cfg_peak = 8'd0; cfg_hold = 8'd0; cfg_cycles = 8'd0;
    step(); step();
    chk("reset duty", int'(duty), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset cfg_err", int'(cfg_err), 0);
    chk("reset phase", int'(phase), 0);
    chk("reset pwm", int'(pwm_out), 0);
    rst = 1'b0;

    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      hi += int'(pwm_out);
    end
    chk("pwm high count duty 0", hi, 0);

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < tbl[r].len; j++) begin
        start = tbl[r].start; stop = tbl[r].stop;
        cfg_floor = tbl[r].fl; cfg_peak = tbl[r].pk;
        cfg_hold = tbl[r].hd; cfg_cycles = tbl[r].cy;
        step();
        chk($sformatf("tbl[%0d].%0d duty", r, j), int'(duty), int'(tbl[r].duty));
        chk($sformatf("tbl[%0d].%0d busy", r, j), int'(busy), int'(tbl[r].busy));
        chk($sformatf("tbl[%0d].%0d done", r, j), int'(done), int'(tbl[r].done));
        chk($sformatf("tbl[%0d].%0d cfg_err", r, j), int'(cfg_err), int'(tbl[r].err));
        chk($sformatf("tbl[%0d].%0d phase", r, j), int'(phase), int'(tbl[r].ph));
      end
    end
    start = 1'b0; stop = 1'b0;

    run_breath(10, 13, 1, 1, 1'b0);
    run_breath(0, 1, 0, 1, 1'b0);
    run_breath(254, 255, 0, 2, 1'b1);
    for (int r = 0; r < 6; r++) begin
      int fl, pk;
      fl = int'($urandom_range(0, 250));
      pk = fl + int'($urandom_range(1, 5));
      run_breath(fl, pk, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1'b1);
    end

    // Long plateaus give a stable duty for 256-cycle PWM windows.
    for (int s = 0; s < 2; s++) begin
      int pk;
      pk = (s == 0) ? 64 : 255;
      start = 1'b1; cfg_floor = 8'(pk - 1); cfg_peak = 8'(pk);
      cfg_hold = 8'd255; cfg_cycles = 8'd1;
      step();
      start = 1'b0;
      repeat (STEP_DIV) step();
      chk("plateau duty", int'(duty), pk);
      step();
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        hi += int'(pwm_out);
      end
      chk($sformatf("pwm high count duty %0d", pk), hi, pk);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("plateau stop busy", int'(busy), 0);
      chk("plateau stop duty", int'(duty), 0);
    end

    start = 1'b1; cfg_floor = 8'd0; cfg_peak = 8'd255; cfg_hold = 8'd0; cfg_cycles = 8'd0;
    step();
    start = 1'b0;
    wait_duty(255, 1200, "infinite reach peak");
    wait_duty(0, 1200, "infinite back to floor");
    chk("infinite busy at floor", int'(busy), 1);
    wait_duty(1, 40, "infinite rises again");
    repeat (STEP_DIV - 1) step();
    chk("infinite pre-tick duty", int'(duty), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop on tick phase", int'(phase), 0);
    chk("stop on tick duty", int'(duty), 0);
    chk("stop on tick done", int'(done), 0);
    chk("stop on tick busy", int'(busy), 0);
    step();
    chk("stop no late done", int'(done), 0);

    start = 1'b1; cfg_floor = 8'd10; cfg_peak = 8'd13; cfg_hold = 8'd1; cfg_cycles = 8'd1;
    step();
    start = 1'b0;
    repeat (13) step();
    chk("midrun phase hold_high", int'(phase), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun rst duty", int'(duty), 0);
    chk("midrun rst busy", int'(busy), 0);
    chk("midrun rst phase", int'(phase), 0);
    chk("midrun rst done", int'(done), 0);
    chk("midrun rst cfg_err", int'(cfg_err), 0);
    chk("midrun rst pwm", int'(pwm_out), 0);
    run_breath(10, 13, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
